// File: rtl/rc4_prga_decrypt.sv
// RC4 PRGA over an external S memory: XORs each keystream byte with a ciphertext byte and writes the plaintext.
// 12 cycles per byte, done rises 12*N cycles after start is accepted; start is ignored while busy.
module rc4_prga_decrypt #(
  parameter int MSG_LEN     = 32,
  parameter int MSG_AW      = 5,
  parameter int CHECK_ASCII = 1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic              fail,
  output logic [7:0]        s_addr,
  output logic [7:0]        s_wdata,
  output logic              s_wren,
  input  logic [7:0]        s_rdata,
  output logic [MSG_AW-1:0] rom_addr,
  input  logic [7:0]        rom_rdata,
  output logic [MSG_AW-1:0] ram_addr,
  output logic [7:0]        ram_wdata,
  output logic              ram_wren
);

  typedef enum logic [3:0] {
    IDLE, RD_SI, WT_SI, LD_SI, RD_SJ, WT_SJ, LD_SJ,
    WR_SI, WR_SJ, RD_F, WT_F, LD_F, WR_DEC, DONE
  } state_t;

  localparam logic [MSG_AW-1:0] K_LAST = MSG_AW'(MSG_LEN - 1);

  state_t            state, state_nxt;
  logic [7:0]        i, j, si, sj, f, enc;
  logic [MSG_AW-1:0] k;
  logic [7:0]        dec;
  logic              dec_text, dec_bad;

  assign dec      = f ^ enc;
  assign dec_text = ((dec >= 8'h61) && (dec <= 8'h7a)) || (dec == 8'h20);
  assign dec_bad  = (CHECK_ASCII != 0) && !dec_text;

  assign busy = (state != IDLE) && (state != DONE);
  assign done = (state == DONE);

  // Read addresses are held through the wait and load states so the
  // registered-address memory still presents the same word when sampled.
  always_comb begin
    state_nxt = state;
    s_addr    = 8'h00;
    s_wdata   = 8'h00;
    s_wren    = 1'b0;
    rom_addr  = '0;
    ram_addr  = '0;
    ram_wdata = 8'h00;
    ram_wren  = 1'b0;
    case (state)
      IDLE, DONE: if (start) state_nxt = RD_SI;
      RD_SI:  begin s_addr = i; state_nxt = WT_SI; end
      WT_SI:  begin s_addr = i; state_nxt = LD_SI; end
      LD_SI:  begin s_addr = i; state_nxt = RD_SJ; end
      RD_SJ:  begin s_addr = j; state_nxt = WT_SJ; end
      WT_SJ:  begin s_addr = j; state_nxt = LD_SJ; end
      LD_SJ:  begin s_addr = j; state_nxt = WR_SI; end
      WR_SI:  begin s_addr = i; s_wdata = sj; s_wren = 1'b1; state_nxt = WR_SJ; end
      WR_SJ:  begin s_addr = j; s_wdata = si; s_wren = 1'b1; state_nxt = RD_F; end
      RD_F:   begin s_addr = si + sj; rom_addr = k; state_nxt = WT_F; end
      WT_F:   begin s_addr = si + sj; rom_addr = k; state_nxt = LD_F; end
      LD_F:   begin s_addr = si + sj; rom_addr = k; state_nxt = WR_DEC; end
      WR_DEC: begin
        ram_addr  = k;
        ram_wdata = dec;
        ram_wren  = 1'b1;
        if (dec_bad || (k == K_LAST)) state_nxt = DONE;
        else                          state_nxt = RD_SI;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
      i     <= 8'h00;
      j     <= 8'h00;
      k     <= '0;
      si    <= 8'h00;
      sj    <= 8'h00;
      f     <= 8'h00;
      enc   <= 8'h00;
      fail  <= 1'b0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE, DONE: if (start) begin
          i    <= 8'h01;
          j    <= 8'h00;
          k    <= '0;
          fail <= 1'b0;
        end
        LD_SI: begin
          si <= s_rdata;
          j  <= j + s_rdata;
        end
        LD_SJ: sj <= s_rdata;
        LD_F: begin
          f   <= s_rdata;
          enc <= rom_rdata;
        end
        WR_DEC: begin
          i <= i + 8'h01;
          k <= k + MSG_AW'(1);
          if (dec_bad) fail <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/rc4_prga_decrypt.md
Name: rc4_prga_decrypt

Overview:
- Keystream-generation and decrypt stage of the RC4 datapath. It is the reader/consumer of the S memory that the KSA state machine fills.
- After the KSA finishes, a start pulse makes this block run the RC4 PRGA over S. It reads ciphertext bytes from the encrypted-message ROM, XORs each with the keystream byte, and writes the plaintext to the decrypted-message RAM.
- An optional ASCII check flags an invalid key, for use by the key-search loop.

Parameters:
- MSG_LEN, 32, number of message bytes processed per run.
- MSG_AW, 5, address width of the message ROM and RAM; 2**MSG_AW must be ≥ MSG_LEN.
- CHECK_ASCII, 1, when 1, abort on the first byte outside {0x61..0x7A, 0x20}.

Ports:
- clk  in  1  system clock (CLK_50M domain).
- reset_n  in  1  asynchronous active-low reset.
- start  in  1  single-cycle launch pulse; ignored while busy.
- busy  out  1  high from start acceptance until done.
- done  out  1  sticky completion flag, cleared by the next accepted start.
- fail  out  1  sticky invalid-character flag, valid when done=1.
- s_addr  out  8  S memory address.
- s_wdata  out  8  S memory write data.
- s_wren  out  1  S memory write enable.
- s_rdata  in  8  S memory read data (q).
- rom_addr  out  MSG_AW  ciphertext ROM address.
- rom_rdata  in  8  ciphertext byte.
- ram_addr  out  MSG_AW  plaintext RAM address.
- ram_wdata  out  8  plaintext byte.
- ram_wren  out  1  plaintext RAM write enable.

Behaviour:
- Memories have a registered address and unregistered q.
- Read timing: an address driven in state X is sampled in state X+2, with one wait state in between.
- Reset (asynchronous, any time, including mid-run):
  - State goes to IDLE.
  - i=0, j=0, k=0.
  - busy=0, done=0, fail=0.
  - All wren outputs and all addr/wdata outputs are 0.
- IDLE / DONE: on start=1, set i=1, j=0, k=0, busy=1, done=0, fail=0, then go to RD_SI. In any other state, start is ignored.
- Per-byte sequence (12 cycles, states in order):
  - RD_SI: s_addr=i.
  - WT_SI: wait.
  - LD_SI: si<=s_rdata; j<=j+s_rdata.
  - RD_SJ: s_addr=j.
  - WT_SJ: wait.
  - LD_SJ: sj<=s_rdata.
  - WR_SI: s_addr=i, s_wdata=sj, s_wren=1.
  - WR_SJ: s_addr=j, s_wdata=si, s_wren=1.
  - RD_F: s_addr=si+sj, rom_addr=k.
  - WT_F: wait.
  - LD_F: f<=s_rdata; enc<=rom_rdata.
  - WR_DEC: ram_addr=k, ram_wdata=f^enc, ram_wren=1; then i<=i+1, k<=k+1.
- Exit from WR_DEC:
  - If CHECK_ASCII=1 and f^enc is not in {0x61..0x7A, 0x20}: the byte is still written, fail<=1, go to DONE.
  - Else if k==MSG_LEN-1: go to DONE.
  - Else: go to RD_SI.
- DONE: done=1, busy=0. fail holds its value. The state holds until the next start or reset.
- Arithmetic: i, j and si+sj are 8-bit modulo-256 and wrap silently.
- i==j: both swap writes target the same address, leaving S[i] unchanged. This is correct RC4 and needs no special case.
- Write enables are high only in WR_SI, WR_SJ and WR_DEC. s_wren and ram_wren are never high in the same cycle.
- Latency: done rises 12*N cycles after the start-accept edge, where N is the number of bytes processed. On a full run this is 12*MSG_LEN = 384 cycles at default.
- S memory contents persist after a run. A second run without re-running the KSA operates on the already-permuted S; this is the caller's responsibility.

Test Plan:
1. S initialised to identity (S[x]=x), enc[0]=0x63, enc[1]=0x64 -> ram[0]=0x61 (f=2), ram[1]=0x61 (f=5). After the run, S[2]=3 and S[3]=2.
2. Identity S, enc[k]=0x20^f for all 32 bytes (f from a golden model) -> all ram bytes are 0x20, fail=0, done asserted exactly 384 cycles after start, busy is low at the same edge.
3. Identity S, enc[0]=0x00, CHECK_ASCII=1 -> ram[0]=0x02, exactly one ram_wren pulse, fail=1, done=1 after 12 cycles.
4. Same stimulus as 3 with CHECK_ASCII=0 -> all 32 bytes written, fail=0.
5. Start pulsed again at cycle 50 of a run -> no restart, and output matches an uninterrupted run. A start while in DONE -> done and fail clear, and a new run begins.
6. reset_n asserted low at cycle 100 -> busy, done, fail and all wren outputs go to 0 asynchronously. No further memory writes occur until the next start.
